// File: rtl/ask_fsk_pkg.sv
// Shared types and constants for the ASK/FSK serial transmitter.
package ask_fsk_pkg;

  localparam int MSG_W      = 5;   // message width in bits
  localparam int BIT_CYCLES = 64;  // clocks per transmitted bit

  localparam logic MODE_ASK = 1'b0;  // on/off keying
  localparam logic MODE_FSK = 1'b1;  // binary frequency-shift keying

  typedef enum logic [1:0] {
    IDLE,
    TX,
    WAIT_REL
  } state_t;

endpackage

// File: rtl/ask_fsk_tx_top_carrier_gen.sv
// Toggling square-wave generator. A restart forces the wave high and clears
// the half-period counter; otherwise, while enabled, the wave toggles every
// half_period clocks. Restart has priority over a coincident toggle.
module carrier_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic [4:0] half_period,
  input  logic       enable,
  output logic       wave
);

  logic [4:0] hcnt;

  // Half-period counter and wave register; restart beats toggle.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      wave <= 1'b0;
    end else if (restart) begin
      hcnt <= '0;
      wave <= 1'b1;
    end else if (enable) begin
      if (hcnt == half_period - 5'd1) begin
        hcnt <= '0;
        wave <= ~wave;
      end else begin
        hcnt <= hcnt + 5'd1;
      end
    end
  end

endmodule

// File: rtl/ask_fsk_tx_top.sv
// ASK/FSK serial transmitter: latches a message on a send request and shifts
// it out MSB first, one bit per BIT_CYCLES clocks, as a keyed square wave.
module ask_fsk_tx_top
  import ask_fsk_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             send,
  input  logic [2:0]       cnt,
  input  logic [MSG_W-1:0] msg,
  input  logic             mode,
  output logic             out
);

  localparam int TW = $clog2(BIT_CYCLES);
  localparam int IW = $clog2(MSG_W);

  state_t           state, state_nxt;
  logic             armed;
  logic [MSG_W-1:0] sh_msg;
  logic             sh_mode;
  logic [2:0]       sh_cnt;
  logic [TW-1:0]    bit_timer;
  logic [IW-1:0]    bit_idx;

  logic       start, bit_end, last_bit, cur_bit, restart, in_tx, wave;
  logic [3:0] h;
  logic [4:0] half_period;

  assign in_tx    = (state == TX);
  assign start    = (state == IDLE) && (send == 1'b1) && armed;
  assign bit_end  = in_tx && (bit_timer == TW'(BIT_CYCLES - 1));
  assign last_bit = (bit_idx == '0);
  assign cur_bit  = sh_msg[bit_idx];
  assign restart  = start || bit_end;

  // Base half-period H = cnt+1; the FSK slow tone for a '0' bit uses 2H.
  assign h           = {1'b0, sh_cnt} + 4'd1;
  assign half_period = (sh_mode == MODE_FSK && !cur_bit) ? {h, 1'b0} : {1'b0, h};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: one frame per send assertion, release required to re-arm.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = TX;
      TX:       if (bit_end && last_bit) state_nxt = WAIT_REL;
      WAIT_REL: if (send == 1'b0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Shadow registers, bit timer, bit index and re-arm flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_msg    <= '0;
      sh_mode   <= MODE_ASK;
      sh_cnt    <= '0;
      bit_timer <= '0;
      bit_idx   <= '0;
      armed     <= 1'b1;
    end else if (start) begin
      sh_msg    <= msg;
      sh_mode   <= mode;
      sh_cnt    <= cnt;
      bit_timer <= '0;
      bit_idx   <= IW'(MSG_W - 1);
      armed     <= 1'b0;
    end else if (in_tx) begin
      if (bit_end) begin
        bit_timer <= '0;
        if (!last_bit) bit_idx <= bit_idx - 1'b1;
      end else begin
        bit_timer <= bit_timer + 1'b1;
      end
    end else if (state == WAIT_REL && send == 1'b0) begin
      armed <= 1'b1;
    end
  end

  carrier_gen u_carrier (
    .clk         (clk),
    .rst         (rst),
    .restart     (restart),
    .half_period (half_period),
    .enable      (in_tx),
    .wave        (wave)
  );

  // Registered output: carrier gated by ASK keying, forced low outside TX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= 1'b0;
    else     out <= in_tx && wave && (sh_mode == MODE_FSK || cur_bit);
  end

endmodule

// File: tb/tb_ask_fsk_tx_top.sv
// Self-checking bench for ask_fsk_tx_top: expected output bits are queued
// when stimulus is applied and compared one per clock as the DUT produces them.
module tb_ask_fsk_tx_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [2:0] cnt;
  logic [4:0] msg;
  logic       mode;
  logic       out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string tag;
    logic  val;
  } exp_t;

  exp_t sb[$];

  ask_fsk_tx_top dut (
    .clk  (clk),
    .rst  (rst),
    .send (send),
    .cnt  (cnt),
    .msg  (msg),
    .mode (mode),
    .out  (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference waveform: sample t (0..319) of a frame.
  function automatic logic model_out(input logic [4:0] m, input logic [2:0] c,
                                     input logic md, input int t);
    int   b  = 4 - t / 64;
    int   tt = t % 64;
    int   hh = int'(c) + 1;
    logic bv = m[b];
    int   hp = (md && !bv) ? 2 * hh : hh;
    return (md || bv) && ((tt / hp) % 2 == 0);
  endfunction

  task automatic push_exp(input string tag, input logic v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: one expected bit per clock, sampled after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, {31'd0, out}, {31'd0, e.val});
    end
  end

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("sb_drain", sb.size(), 0);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) push_exp($sformatf("%s_%0d", tag, i), 1'b0);
    drain();
  endtask

  // Applies a send request at a negedge and queues the expected waveform:
  // one idle cycle, the first lim frame samples, then hold idle cycles.
  task automatic start_frame(input logic [4:0] m, input logic [2:0] c, input logic md,
                             input int lim, input int hold, input string tag);
    msg  = m;
    cnt  = c;
    mode = md;
    send = 1'b1;
    push_exp({tag, "_lead"}, 1'b0);
    for (int t = 0; t < lim; t++)
      push_exp($sformatf("%s_t%0d", tag, t), model_out(m, c, md, t));
    for (int i = 0; i < hold; i++)
      push_exp($sformatf("%s_hold%0d", tag, i), 1'b0);
  endtask

  initial begin
    rst  = 1'b1;
    send = 1'b0;
    cnt  = '0;
    msg  = '0;
    mode = 1'b0;
    #2;
    check("reset_out", {31'd0, out}, 0);

    // 1: idle after reset.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(200, "idle");

    // 2: ASK, fastest carrier, send held after frame.
    start_frame(5'b11010, 3'd0, 1'b0, 320, 100, "ask");
    drain();
    send = 1'b0;
    idle(3, "ask_rel");

    // 3 + 5: FSK frame, then a short low pulse re-arms a second frame.
    start_frame(5'b11010, 3'd0, 1'b1, 320, 20, "fsk");
    drain();
    send = 1'b0;
    idle(1, "pulse");
    start_frame(5'b00101, 3'd3, 1'b1, 320, 60, "fsk2");
    drain();
    send = 1'b0;
    idle(3, "fsk2_rel");

    // 4: slowest carrier; inputs change and send drops mid-frame.
    start_frame(5'b10000, 3'd7, 1'b1, 320, 20, "slow");
    repeat (100) @(negedge clk);
    msg  = 5'b01111;
    cnt  = 3'd0;
    mode = 1'b0;
    repeat (50) @(negedge clk);
    send = 1'b0;
    drain();
    idle(10, "slow_idle");

    // 6: reset in the middle of bit 2, then a fresh frame from the MSB.
    start_frame(5'b10111, 3'd0, 1'b1, 160, 0, "abort");
    drain();
    rst = 1'b1;
    #1;
    check("async_rst_out", {31'd0, out}, 0);
    send = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(5, "post_rst");
    start_frame(5'b01101, 3'd1, 1'b0, 320, 10, "restart");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
